// File: rtl/io_uart_tx.sv
// Output-port sink for the core: buffers 32-bit words in a small FIFO and
// sends each one as four UART 8N1 bytes, least significant byte first.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       din,
  input  logic              din_valid,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]  FULL     = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Handshake: din_valid is a one-cycle strobe with no ready; a word offered
  // while the FIFO is full (and not popping on that edge) is dropped.
  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              pop, wr_en, timer_done;

  always_comb begin
    pop        = (state_q == IDLE) && (count_q != '0);
    wr_en      = din_valid && ((count_q != FULL) || pop);
    timer_done = (clk_cnt_q == CNT_LAST);

    wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q | (din_valid & ~wr_en);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    state_d    = state_q;
    clk_cnt_d  = timer_done ? '0 : clk_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;

    // The shift register moves right once per data bit, so the word leaves
    // as bits 0..31 in order, which is byte 0 first and LSB first per byte.
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (timer_done) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (timer_done) begin
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (timer_done) begin
          if (byte_idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx and busy are registered from the next-state values.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (count_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: word-level reference model predicting the tx line,
// plus a UART receiver that decodes bytes against an expected byte queue.
module tb_io_uart_tx;
  localparam int CPB    = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int FRAME  = 40 * CPB;

  logic              clk;
  logic              reset;
  logic [31:0]       din;
  logic              din_valid;
  logic              tx;
  logic              busy;
  logic              overflow;
  logic [ADDR_W:0]   count;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .tx(tx), .busy(busy), .overflow(overflow), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] m_word;
  bit          m_active;
  int          m_t;
  bit          m_ovf;
  bit          m_pop;
  bit          m_rst_seen;

  // tx level at cycle offset t within a 40-bit word frame.
  function automatic logic exp_bit(input logic [31:0] w, input int t);
    int b, f, k;
    b = t / CPB;
    f = b / 10;
    k = b % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return w[f * 8 + k - 1];
  endfunction

  always @(posedge clk) begin
    m_rst_seen = reset;
    if (reset) begin
      exp_q.delete();
      exp_byte_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_pop = !m_active && (exp_q.size() > 0);
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) m_active = 1'b0;
      end else if (m_pop) begin
        m_word   = exp_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (din_valid === 1'b1) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(din);
          for (int b = 0; b < 4; b++) exp_byte_q.push_back(din[8*b +: 8]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", tx, m_active ? exp_bit(m_word, m_t) : 1'b1);
      chk("busy", busy, (exp_q.size() != 0) || m_active);
      chk("count", count, exp_q.size());
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- UART receiver / byte scoreboard ----------------
  bit         rx_active;
  int         rx_cnt;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (m_rst_seen || !chk_en) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_active && (rx_cnt % CPB) == CPB / 2) begin
      if (rx_cnt / CPB == 0) begin
        chk("rx_start", tx, 1'b0);
      end else if (rx_cnt / CPB <= 8) begin
        rx_byte[rx_cnt / CPB - 1] = tx;
      end else begin
        chk("rx_stop", tx, 1'b1);
        if (exp_byte_q.size() == 0) fail("rx_unexpected_byte");
        else chk("rx_byte", rx_byte, exp_byte_q.pop_front());
        got_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
  endtask

  // Called at a negedge: drives one strobe for the current cycle.
  task automatic drive_word(input logic [31:0] w);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk("drain_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain_bytes_left", exp_byte_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low_cnt;
    bit found;
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset();
    chk_en = 1'b1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);

    // Single word: start bit at cycle 2, idle again at cycle 162.
    drive_word(32'h44332211);
    chk("t1_count_c1", count, 1);
    chk("t1_tx_c1", tx, 1'b1);
    @(negedge clk);
    chk("t1_tx_c2", tx, 1'b0);
    repeat (159) @(negedge clk);
    chk("t1_tx_c161", tx, 1'b1);
    chk("t1_busy_c161", busy, 1'b1);
    @(negedge clk);
    chk("t1_tx_c162", tx, 1'b1);
    chk("t1_busy_c162", busy, 1'b0);
    chk("t1_nbytes", got_q.size(), 4);
    chk("t1_b0", got_q[0], 8'h11);
    chk("t1_b1", got_q[1], 8'h22);
    chk("t1_b2", got_q[2], 8'h33);
    chk("t1_b3", got_q[3], 8'h44);

    // Two back-to-back words: exactly one idle cycle between them.
    apply_reset();
    din = 32'h0000_0000; din_valid = 1'b1;
    @(negedge clk);
    din = 32'hFFFF_FFFF;
    @(negedge clk);
    din_valid = 1'b0;
    chk("t2_tx_c2", tx, 1'b0);
    repeat (160) @(negedge clk);
    chk("t2_tx_c162_idle", tx, 1'b1);
    chk("t2_count_c162", count, 1);
    @(negedge clk);
    chk("t2_tx_c163_start", tx, 1'b0);
    wait_idle(2000);
    chk("t2_nbytes", got_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_byte", got_q[i], (i < 4) ? 8'h00 : 8'hFF);
    chk("t2_overflow", overflow, 1'b0);

    // Ten consecutive strobes into an 8-deep FIFO: word 10 dropped.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        chk("t3_ovf_c9", overflow, 1'b0);
        chk("t3_count_c9", count, 8);
      end
      din = 32'(i + 1); din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk("t3_ovf_c10", overflow, 1'b1);
    chk("t3_count_c10", count, 8);
    wait_idle(4000);
    chk("t3_nbytes", got_q.size(), 36);
    for (int i = 0; i < 36; i++)
      chk("t3_byte", got_q[i], (i % 4 == 0) ? 8'(i / 4 + 1) : 8'h00);
    chk("t3_ovf_after", overflow, 1'b1);

    // Full FIFO with the serializer idle: a write on the pop edge is kept.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      din = $urandom; din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk("t4_fill_count", count, 8);
    for (int j = 0; j < 2 * DEPTH; j++) begin
      found = 1'b0;
      for (int w = 0; w < 400 && !found; w++) begin
        if (!m_active && exp_q.size() == DEPTH) found = 1'b1;
        else @(negedge clk);
      end
      chk("t4_reach_full_idle", found, 1'b1);
      drive_word($urandom);
      chk("t4_count_kept", count, 8);
      chk("t4_no_overflow", overflow, 1'b0);
    end
    wait_idle(8000);
    chk("t4_nbytes", got_q.size(), 4 * (9 + 2 * DEPTH));

    // Reset while byte 2 of the first word is in its data bits.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      din = $urandom; din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    repeat (92) @(negedge clk);
    chk("t5_count_before", count, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_tx", tx, 1'b1);
    chk("t5_count", count, 0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_overflow", overflow, 1'b0);
    low_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    chk("t5_no_start", low_cnt, 0);
    got_q.delete();
    drive_word(32'hA5C3_0F81);
    @(negedge clk);
    chk("t5_new_start", tx, 1'b0);
    wait_idle(2000);
    chk("t5_nbytes", got_q.size(), 4);

    // Random traffic, including overflow bursts.
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      din       = $urandom;
      din_valid = ($urandom_range(0, 99) < 4);
      @(negedge clk);
    end
    din_valid = 1'b0;
    wait_idle(20000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Sink for the core's output port: captures 32-bit words presented on dout/dout_ready (one-cycle strobe on a store to address 0).
- Buffers words in a small FIFO and serializes each as four UART 8N1 bytes on a single tx line.
- The core has no backpressure, so words arriving while the FIFO is full are dropped and flagged.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be ≥ 2.
- DEPTH, 8, FIFO depth in 32-bit words; must be a power of two.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- din  input  32  word from core dout.
- din_valid  input  1  from core dout_ready; one-cycle write strobe.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while FIFO non-empty or serializer not IDLE.
- overflow  output  1  sticky; a word was dropped.
- count  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high, on clk):
  - FIFO pointers = 0, count = 0, overflow = 0, state = IDLE, tx = 1, busy = 0.
  - FIFO storage contents need not be cleared.
  - Reset mid-frame aborts the frame: tx = 1 from the edge where reset is sampled, and the partial word is lost.
- FIFO write:
  - On a clk edge with din_valid = 1, din is stored at wr_ptr and wr_ptr increments modulo DEPTH.
  - The write is accepted if count < DEPTH, or if count == DEPTH and a pop occurs on the same edge.
  - Otherwise the word is discarded, overflow is set to 1 and stays 1 until reset, and pointers and count are unchanged.
- FIFO pop:
  - Occurs on an edge where state == IDLE and count > 0.
  - The word at rd_ptr is loaded into a 32-bit shift register and rd_ptr increments modulo DEPTH.
  - Simultaneous accepted write and pop leave count unchanged.
  - Pointers wrap without skipping entries.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. A pop moves to START with byte_idx = 0, and the bit timer is cleared.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit_idx = 0.
  - DATA: tx = current bit of the current byte, LSB first, each held CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. If byte_idx < 3: increment byte_idx and go to START with no idle gap. If byte_idx == 3: go to IDLE.
  - Byte order: byte_idx 0 = din[7:0], 1 = din[15:8], 2 = din[23:16], 3 = din[31:24].
- Timing:
  - Bit timer counts 0..CLKS_PER_BIT-1; state and bit changes occur on terminal count.
  - tx is registered.
  - Latency from din_valid (cycle N, FIFO empty, IDLE): count = 1 in cycle N+1; pop at the end of cycle N+1; start bit on tx from cycle N+2.
  - One word occupies exactly 40*CLKS_PER_BIT cycles on tx.
  - Back-to-back words from the FIFO are separated by exactly one IDLE cycle (tx = 1).
- Status outputs:
  - busy = (count != 0) | (state != IDLE), registered-equivalent.
  - count is the registered occupancy after the edge.

Test Plan:
- CLKS_PER_BIT=4. Write 0x44332211 once from reset.
  - tx low from cycle 2.
  - Bytes 0x11, 0x22, 0x33, 0x44 decode correctly, each framed with start 0 and stop 1.
  - tx returns idle at cycle 162; busy falls at the same edge.
- Write 0x00000000 then 0xFFFFFFFF on consecutive cycles.
  - 8 bytes decode as four 0x00 then four 0xFF.
  - Exactly one idle cycle between the two words.
  - overflow stays 0.
- DEPTH=8. Assert din_valid for 10 consecutive cycles (cycles 0..9) with words 1..10.
  - First pop is at cycle 1.
  - Word 10 is dropped; overflow = 1 from cycle 10; count = 8.
  - Words 1..9 are transmitted in order.
  - overflow stays 1 after all traffic drains.
- FIFO full, serializer in IDLE, din_valid asserted on the pop edge.
  - Write is accepted; count stays at DEPTH; overflow stays 0.
  - Run at least 2*DEPTH words to cover pointer wrap; all words arrive in order.
- Assert reset during the DATA state of byte 2 with 3 words queued.
  - tx = 1 and count = 0 on the next cycle; busy = 0; overflow = 0.
  - No further start bit occurs until a new din_valid.
